// File: rtl/dtc_pkg.sv
// Shared constants for the dtc phase supervisor: state and fault encodings,
// current/watchdog widths, the offset-binary zero code and a magnitude helper.
package dtc_pkg;

  localparam int unsigned CurW  = 16;
  localparam int unsigned WdogW = 24;

  // Offset-binary code for zero current
  localparam logic [CurW-1:0] ZeroCur = 16'h8000;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StPrecharge = 3'd1;
  localparam logic [2:0] StRamp      = 3'd2;
  localparam logic [2:0] StRun       = 3'd3;
  localparam logic [2:0] StFault     = 3'd4;

  localparam logic [1:0] FcNone    = 2'd0;
  localparam logic [1:0] FcOvercur = 2'd1;
  localparam logic [1:0] FcShoot   = 2'd2;
  localparam logic [1:0] FcWdog    = 2'd3;

  // |a - b| with a 17-bit signed difference so no operand pair can overflow
  function automatic logic [CurW:0] abs_diff(input logic [CurW-1:0] a,
                                             input logic [CurW-1:0] b);
    logic signed [CurW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    abs_diff = d[CurW] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/dtc_slew.sv
// Slew limiter: one combinational step of cur toward tgt by at most slew,
// landing exactly on tgt when it is within reach, clamped to the code range.
module dtc_slew
  import dtc_pkg::*;
(
  input  logic [CurW-1:0] cur,
  input  logic [CurW-1:0] tgt,
  input  logic [CurW-1:0] slew,
  output logic [CurW-1:0] next
);

  logic [CurW:0] up;
  logic [CurW:0] dn;

  // Step toward the target; the 17-bit sums catch carry/borrow for clamping
  always_comb begin
    up   = {1'b0, cur} + {1'b0, slew};
    dn   = {1'b0, cur} - {1'b0, slew};
    next = cur;
    if (abs_diff(tgt, cur) <= {1'b0, slew}) begin
      next = tgt;
    end else if (tgt > cur) begin
      next = up[CurW] ? '1 : up[CurW-1:0];
    end else begin
      next = dn[CurW] ? '0 : dn[CurW-1:0];
    end
  end

endmodule

// File: rtl/dtc_sched.sv
// Per-phase supervisor for one dtc hysteresis controller: sequences
// idle -> bootstrap precharge -> slew-limited ramp -> run, gates the MOSFET
// drives and latches overcurrent / shoot-through / watchdog faults.
// Build option DTC_SCHED_BRAKE_EN: hold the low side on during a watchdog fault.
module dtc_sched
  import dtc_pkg::*;
#(
  parameter logic [CurW-1:0]  ZERO        = ZeroCur,
  parameter logic [15:0]      PRECHARGE_T = 16'd1250,
  parameter logic [15:0]      RAMP_DIV    = 16'd125,
  parameter logic [WdogW-1:0] WDOG_T      = 24'd1250000
) (
  input  logic            c,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [CurW-1:0] cmd_tgt,
  input  logic            cmd_valid,
  input  logic [CurW-1:0] i_est,
  input  logic            i_est_valid,
  input  logic [CurW-1:0] i_limit,
  input  logic [CurW-1:0] slew,
  input  logic            fault_clear,
  input  logic            dtc_hi,
  input  logic            dtc_lo,
  output logic [CurW-1:0] i_tgt,
  output logic            hi,
  output logic            lo,
  output logic [2:0]      state,
  output logic            fault,
  output logic [1:0]      fault_code
);

  logic [2:0]       st_q, st_d;
  logic [15:0]      pre_q, pre_d;
  logic [15:0]      div_q, div_d;
  logic [WdogW-1:0] wd_q, wd_d;
  logic [CurW-1:0]  cmd_q, cmd_d;
  logic [CurW-1:0]  i_tgt_q, i_tgt_d;
  logic             hi_q, hi_d;
  logic             lo_q, lo_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;

  logic            run_like;
  logic            run_next;
  logic            fire;
  logic            shoot;
  logic            overcur;
  logic            wdog;
  logic [1:0]      new_code;
  logic [CurW-1:0] slew_next;

  dtc_slew u_slew (
    .cur  (i_tgt_q),
    .tgt  (cmd_q),
    .slew (slew),
    .next (slew_next)
  );

  // Fault detection and slew-divider tick, all from the current state
  always_comb begin
    run_like = (st_q == StRamp) || (st_q == StRun);
    fire     = run_like && (div_q == RAMP_DIV - 16'd1);
    shoot    = run_like && dtc_hi && dtc_lo;
    overcur  = i_est_valid && (abs_diff(i_est, ZERO) > {1'b0, i_limit});
    // Counting the current tick makes the fault land WDOG_T+1 ticks after RAMP entry
    wdog     = run_like && !cmd_valid &&
               (({1'b0, wd_q} + 25'd1) > {1'b0, WDOG_T});
    if (shoot) begin
      new_code = FcShoot;
    end else if (overcur) begin
      new_code = FcOvercur;
    end else if (wdog) begin
      new_code = FcWdog;
    end else begin
      new_code = FcNone;
    end
  end

  // Next-state, counters and fault latch
  always_comb begin
    st_d    = st_q;
    pre_d   = pre_q;
    div_d   = div_q;
    wd_d    = wd_q;
    fault_d = fault_q;
    code_d  = code_q;
    cmd_d   = cmd_valid ? cmd_tgt : cmd_q;
    if ((st_q != StFault) && (new_code != FcNone)) begin
      st_d    = StFault;
      fault_d = 1'b1;
      code_d  = new_code;
    end else begin
      case (st_q)
        StIdle: begin
          if (enable && !fault_q) begin
            st_d  = StPrecharge;
            pre_d = '0;
          end
        end
        StPrecharge: begin
          if (!enable) begin
            st_d = StIdle;
          end else if (pre_q == PRECHARGE_T - 16'd1) begin
            st_d  = StRamp;
            div_d = '0;
            wd_d  = '0;
          end else begin
            pre_d = pre_q + 16'd1;
          end
        end
        StRamp, StRun: begin
          if (!enable) begin
            st_d = StIdle;
          end else begin
            div_d = fire ? '0 : div_q + 16'd1;
            wd_d  = cmd_valid ? '0 : wd_q + 24'd1;
            if ((st_q == StRamp) && (i_tgt_q == cmd_q)) begin
              st_d = StRun;
            end
          end
        end
        StFault: begin
          if (fault_clear && !enable) begin
            st_d    = StIdle;
            fault_d = 1'b0;
            code_d  = FcNone;
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  // Registered outputs derived from the next state so they move with it
  always_comb begin
    run_next = (st_d == StRamp) || (st_d == StRun);
    i_tgt_d  = run_next ? (fire ? slew_next : i_tgt_q) : ZERO;
    // Never pass both requests through, even when a shoot-through is not yet a fault
    hi_d     = run_next && dtc_hi && !dtc_lo;
    lo_d     = (st_d == StPrecharge) || (run_next && dtc_lo && !dtc_hi);
`ifdef DTC_SCHED_BRAKE_EN
    if ((st_d == StFault) && (code_d == FcWdog)) begin
      hi_d = 1'b0;
      lo_d = 1'b1;
    end
`endif
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge c) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      pre_q   <= '0;
      div_q   <= '0;
      wd_q    <= '0;
      cmd_q   <= ZERO;
      i_tgt_q <= ZERO;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FcNone;
    end else begin
      st_q    <= st_d;
      pre_q   <= pre_d;
      div_q   <= div_d;
      wd_q    <= wd_d;
      cmd_q   <= cmd_d;
      i_tgt_q <= i_tgt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign i_tgt      = i_tgt_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign state      = st_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_dtc_sched.sv
// Directed bench for dtc_sched with short precharge, divider and watchdog.
module tb_dtc_sched;

  logic        c = 1'b0;
  logic        rst_n, enable, cmd_valid, i_est_valid, fault_clear, dtc_hi, dtc_lo;
  logic [15:0] cmd_tgt, i_est, i_limit, slew, i_tgt;
  logic        hi, lo, fault;
  logic [2:0]  state;
  logic [1:0]  fault_code;

  int n_chk  = 0;
  int n_pass = 0;
  int n;
  int e;

`ifdef DTC_SCHED_BRAKE_EN
  localparam logic BrakeLo = 1'b1;
`else
  localparam logic BrakeLo = 1'b0;
`endif

  always #5 c = ~c;

  dtc_sched #(
    .PRECHARGE_T (16'd100),
    .RAMP_DIV    (16'd4),
    .WDOG_T      (24'd50)
  ) dut (
    .c           (c),
    .rst_n       (rst_n),
    .enable      (enable),
    .cmd_tgt     (cmd_tgt),
    .cmd_valid   (cmd_valid),
    .i_est       (i_est),
    .i_est_valid (i_est_valid),
    .i_limit     (i_limit),
    .slew        (slew),
    .fault_clear (fault_clear),
    .dtc_hi      (dtc_hi),
    .dtc_lo      (dtc_lo),
    .i_tgt       (i_tgt),
    .hi          (hi),
    .lo          (lo),
    .state       (state),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  // Inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(negedge c);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_state(input logic [2:0] want, input int bound);
    int k;
    k = 0;
    while (state !== want && k < bound) begin
      tick();
      k++;
    end
  endtask

  task automatic check_off(input string tag);
    check({tag, "_hi"}, {31'd0, hi}, 32'd0);
    check({tag, "_lo"}, {31'd0, lo}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cmd_valid = 1'b0; cmd_tgt = 16'h8000;
    i_est = 16'h8000; i_est_valid = 1'b0; i_limit = 16'hFFFF; slew = 16'h0010;
    fault_clear = 1'b0; dtc_hi = 1'b0; dtc_lo = 1'b0;
    tick(); tick();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_itgt", {16'd0, i_tgt}, 32'h8000);
    check_off("rst");
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_code", {30'd0, fault_code}, 32'd0);

    // Bring-up
    rst_n = 1'b1; cmd_tgt = 16'h8040; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("idle_hold", {29'd0, state}, 32'd0);
    enable = 1'b1;
    tick();
    check("pre_state", {29'd0, state}, 32'd1);
    n = 0;
    while (lo === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check("pre_lo_ticks", n, 32'd100);
    check("ramp_entry", {29'd0, state}, 32'd2);
    check("ramp_entry_lo", {31'd0, lo}, 32'd0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      e = 32'h8000 + 16 * (k / 4);
      if (e > 32'h8040) e = 32'h8040;
      check($sformatf("ramp_itgt_%0d", k), {16'd0, i_tgt}, e);
      check($sformatf("ramp_state_%0d", k), {29'd0, state}, (k == 17) ? 32'd3 : 32'd2);
    end
    dtc_hi = 1'b1;
    tick();
    check("run_hi", {31'd0, hi}, 32'd1);
    check("run_hi_lo", {31'd0, lo}, 32'd0);
    dtc_hi = 1'b0; dtc_lo = 1'b1;
    tick();
    check("run_lo", {31'd0, lo}, 32'd1);
    check("run_lo_hi", {31'd0, hi}, 32'd0);

    // Shoot-through in RUN
    dtc_hi = 1'b1; dtc_lo = 1'b1;
    tick();
    dtc_hi = 1'b0; dtc_lo = 1'b0;
    check_off("st");
    check("st_state", {29'd0, state}, 32'd4);
    check("st_fault", {31'd0, fault}, 32'd1);
    check("st_code", {30'd0, fault_code}, 32'd2);
    check("st_itgt", {16'd0, i_tgt}, 32'h8000);

    // Clear is ignored while enable is high
    fault_clear = 1'b1;
    tick();
    check("clr_ignored", {29'd0, state}, 32'd4);
    enable = 1'b0;
    tick();
    fault_clear = 1'b0;
    check("clr_state", {29'd0, state}, 32'd0);
    check("clr_fault", {31'd0, fault}, 32'd0);
    check("clr_code", {30'd0, fault_code}, 32'd0);

    // Overcurrent: magnitude 0x100 is at the limit, 0x101 is over
    i_limit = 16'h0100; i_est = 16'h7F00; i_est_valid = 1'b1;
    tick();
    check("oc_edge", {29'd0, state}, 32'd0);
    i_est = 16'h7EFF;
    tick();
    i_est_valid = 1'b0;
    check("oc_state", {29'd0, state}, 32'd4);
    check("oc_code", {30'd0, fault_code}, 32'd1);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("oc_clr", {29'd0, state}, 32'd0);

    // Overcurrent and shoot-through on the same tick
    enable = 1'b1;
    wait_state(3'd2, 300);
    check("both_ramp", {29'd0, state}, 32'd2);
    dtc_hi = 1'b1; dtc_lo = 1'b1; i_est_valid = 1'b1;
    tick();
    dtc_hi = 1'b0; dtc_lo = 1'b0; i_est_valid = 1'b0;
    check("both_state", {29'd0, state}, 32'd4);
    check("both_code", {30'd0, fault_code}, 32'd2);
    check_off("both");
    enable = 1'b0; fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;

    // Watchdog: no cmd_valid after RAMP entry
    enable = 1'b1;
    wait_state(3'd2, 300);
    check("wd_ramp", {29'd0, state}, 32'd2);
    repeat (50) tick();
    check("wd_t50", {29'd0, state}, 32'd3);
    tick();
    check("wd_state", {29'd0, state}, 32'd4);
    check("wd_code", {30'd0, fault_code}, 32'd3);
    check("wd_hi", {31'd0, hi}, 32'd0);
    check("wd_lo", {31'd0, lo}, {31'd0, BrakeLo});
    enable = 1'b0; fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("wd_clr", {29'd0, state}, 32'd0);

    // Full-scale target with full-scale slew, then back down to 0
    slew = 16'hFFFF; cmd_tgt = 16'hFFFF; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; enable = 1'b1;
    wait_state(3'd2, 300);
    repeat (4) tick();
    check("max_itgt", {16'd0, i_tgt}, 32'hFFFF);
    tick();
    check("max_run", {29'd0, state}, 32'd3);
    cmd_tgt = 16'h0000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    check("min_itgt", {16'd0, i_tgt}, 32'h0000);

    // Zero slew freezes the target
    slew = 16'h0000; cmd_tgt = 16'h1234; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (8) tick();
    check("frozen", {16'd0, i_tgt}, 32'h0000);
    slew = 16'h0010;
    repeat (4) tick();
    check("unfrozen", {16'd0, i_tgt}, 32'h0010);

    // Reset in the middle of a downward ramp
    enable = 1'b0;
    tick();
    check("dis_idle", {29'd0, state}, 32'd0);
    enable = 1'b1;
    wait_state(3'd2, 300);
    repeat (5) tick();
    dtc_hi = 1'b1;
    tick();
    check("mid_state", {29'd0, state}, 32'd2);
    check("mid_itgt", {16'd0, i_tgt}, 32'h7FF0);
    check("mid_hi", {31'd0, hi}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mrst_state", {29'd0, state}, 32'd0);
    check("mrst_itgt", {16'd0, i_tgt}, 32'h8000);
    check_off("mrst");
    check("mrst_fault", {31'd0, fault}, 32'd0);
    check("mrst_code", {30'd0, fault_code}, 32'd0);
    // cmd_reg came back as ZERO, so RAMP completes immediately
    rst_n = 1'b1; dtc_hi = 1'b0;
    wait_state(3'd2, 300);
    tick();
    check("mrst_cmd_zero", {29'd0, state}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
